// File: rtl/wb_arb_pkg.sv
// Shared definitions for the two-master Wishbone arbiter: grant encoding,
// priority encoding and the default ack-watchdog timeout.
package wb_arb_pkg;

   // Grant state: which master (if any) owns the slave
   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      GNT_M0 = 2'b01,
      GNT_M1 = 2'b10
   } gnt_e;

   // Favoured master for the next simultaneous request
   localparam logic PRIO_M0 = 1'b0;
   localparam logic PRIO_M1 = 1'b1;

   // Cycles a granted strobe may wait for an ack before err fires
   localparam int unsigned TIMEOUT_CYCLES_DEF = 16;

endpackage

// File: rtl/wb_ack_watchdog.sv
// Ack watchdog: counts consecutive stalled strobe cycles of the granted
// master and flags the cycle in which the limit is reached.
module wb_ack_watchdog
   import wb_arb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
   parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic stb_i,      // strobe of the granted master, 0 when idle
   input  logic ack_i,      // slave ack
   input  logic clr_i,      // grant is being released this cycle
   output logic timeout_o   // stall limit reached in this cycle
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] wdog_q, wdog_d;

   // An ack in the final cycle wins over the timeout
   assign timeout_o = (wdog_q == LAST) & stb_i & ~ack_i;

   // Next count: restart on any progress, release, idle strobe or fired error
   always_comb begin
      wdog_d = wdog_q + 1'b1;
      if (clr_i | ack_i | ~stb_i | timeout_o) begin
         wdog_d = '0;
      end
   end

   // Counter register with synchronous reset
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wdog_q <= '0;
      end else begin
         wdog_q <= wdog_d;
      end
   end

endmodule

// File: rtl/wb_arbiter_2m.sv
// Two-master, one-slave Wishbone classic arbiter. Registered round-robin
// grant held for a master's whole bus cycle, with an ack watchdog that
// terminates a stalled access with a one-cycle err pulse.
module wb_arbiter_2m
   import wb_arb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_ni,
   // master 0
   input  logic [31:0] m0_adr_i,
   input  logic [31:0] m0_dat_i,
   input  logic [3:0]  m0_sel_i,
   input  logic        m0_we_i,
   input  logic        m0_cyc_i,
   input  logic        m0_stb_i,
   output logic        m0_ack_o,
   output logic        m0_err_o,
   output logic [31:0] m0_dat_o,
   // master 1
   input  logic [31:0] m1_adr_i,
   input  logic [31:0] m1_dat_i,
   input  logic [3:0]  m1_sel_i,
   input  logic        m1_we_i,
   input  logic        m1_cyc_i,
   input  logic        m1_stb_i,
   output logic        m1_ack_o,
   output logic        m1_err_o,
   output logic [31:0] m1_dat_o,
   // slave
   output logic [31:0] s_adr_o,
   output logic [31:0] s_dat_o,
   output logic [3:0]  s_sel_o,
   output logic        s_we_o,
   output logic        s_cyc_o,
   output logic        s_stb_o,
   input  logic        s_ack_i,
   input  logic [31:0] s_dat_i
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   gnt_e gnt_q;
   logic prio_q;

   logic g_cyc, g_stb;
   logic leave;
   logic timeout_now;

   // Slave-side mux; address/data/sel/we follow M0 unless M1 owns the bus
   always_comb begin
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
      s_sel_o = m0_sel_i;
      s_we_o  = m0_we_i;
      g_cyc   = 1'b0;
      g_stb   = 1'b0;
      unique case (gnt_q)
         GNT_M0: begin
            g_cyc = m0_cyc_i;
            g_stb = m0_stb_i;
         end
         GNT_M1: begin
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
            s_sel_o = m1_sel_i;
            s_we_o  = m1_we_i;
            g_cyc   = m1_cyc_i;
            g_stb   = m1_stb_i;
         end
         default: ;
      endcase
   end

   assign s_cyc_o = g_cyc;
   assign s_stb_o = g_stb & ~timeout_now;

   // Responses only ever reach the granted master
   assign m0_ack_o = (gnt_q == GNT_M0) & s_ack_i;
   assign m1_ack_o = (gnt_q == GNT_M1) & s_ack_i;
   assign m0_err_o = (gnt_q == GNT_M0) & timeout_now;
   assign m1_err_o = (gnt_q == GNT_M1) & timeout_now;

   // Read data is broadcast; ack alone qualifies it
   assign m0_dat_o = s_dat_i;
   assign m1_dat_o = s_dat_i;

   // Owner drops cyc: the grant changes at this edge
   assign leave = (gnt_q != IDLE) & ~g_cyc;

   wb_ack_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .CNT_W          (CNT_W)
   ) u_wdog (
      .clk_i     (wb_clk_i),
      .rst_ni    (wb_rst_ni),
      .stb_i     (g_stb),
      .ack_i     (s_ack_i),
      .clr_i     (leave),
      .timeout_o (timeout_now)
   );

   // Grant FSM: hold for the whole bus cycle, hand over directly when the
   // other master is already waiting, and favour the other master next time
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_ni) begin
         gnt_q  <= IDLE;
         prio_q <= PRIO_M0;
      end else begin
         unique case (gnt_q)
            IDLE: begin
               if (m0_cyc_i && m1_cyc_i) begin
                  gnt_q <= (prio_q == PRIO_M1) ? GNT_M1 : GNT_M0;
               end else if (m0_cyc_i) begin
                  gnt_q <= GNT_M0;
               end else if (m1_cyc_i) begin
                  gnt_q <= GNT_M1;
               end
            end
            GNT_M0: begin
               if (!m0_cyc_i) begin
                  prio_q <= PRIO_M1;
                  gnt_q  <= m1_cyc_i ? GNT_M1 : IDLE;
               end
            end
            GNT_M1: begin
               if (!m1_cyc_i) begin
                  prio_q <= PRIO_M0;
                  gnt_q  <= m0_cyc_i ? GNT_M0 : IDLE;
               end
            end
            default: gnt_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Directed bench for wb_arbiter_2m: a small memory slave with selectable
// ack behaviour, a per-cycle reference model of ownership/priority/stall,
// and literal checks for latency, handover, round-robin and the watchdog.
module tb_wb_arbiter_2m;

   localparam int TMO = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat;
   logic [3:0]  m0_sel, m1_sel;
   logic        m0_we, m0_cyc, m0_stb, m1_we, m1_cyc, m1_stb;
   logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
   logic [31:0] m0_dat_o, m1_dat_o;
   logic [31:0] s_adr_o, s_dat_o;
   logic [3:0]  s_sel_o;
   logic        s_we_o, s_cyc_o, s_stb_o;
   logic        s_ack_i;
   logic [31:0] s_dat_i;

   int nchk = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   wb_arbiter_2m #(.TIMEOUT_CYCLES(TMO)) dut (
      .wb_clk_i(clk), .wb_rst_ni(rst_n),
      .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_we_i(m0_we),
      .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
      .m0_dat_o(m0_dat_o),
      .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_we_i(m1_we),
      .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
      .m1_dat_o(m1_dat_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_ack_i(s_ack_i), .s_dat_i(s_dat_i)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // ---------------- slave: mode 0 = ack next cycle, 1 = never, 2 = ack on stb cycle TMO
   logic [31:0] mem [0:255];
   int slv_mode = 0;
   int slv_cnt  = 0;

   initial for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
   initial begin s_ack_i = 1'b0; s_dat_i = '0; end

   always @(posedge clk) begin
      if (s_cyc_o && s_stb_o && !s_ack_i) begin
         slv_cnt <= slv_cnt + 1;
         if (slv_mode == 0 || (slv_mode == 2 && slv_cnt == TMO - 2)) begin
            s_ack_i <= 1'b1;
            s_dat_i <= mem[s_adr_o[9:2]];
            if (s_we_o)
               for (int b = 0; b < 4; b++)
                  if (s_sel_o[b]) mem[s_adr_o[9:2]][8*b +: 8] <= s_dat_o[8*b +: 8];
         end
      end else begin
         s_ack_i <= 1'b0;
         slv_cnt <= 0;
      end
   end

   // ---------------- reference model: owner 0=none 1=M0 2=M1, favoured master, stall count
   bit mdl_on = 1'b0;
   int own = 0, fav = 0, stall = 0;

   always @(negedge clk) begin
      logic gc, gs, tmo, c0, c1;
      gc  = (own == 1) ? m0_cyc : (own == 2) ? m1_cyc : 1'b0;
      gs  = (own == 1) ? m0_stb : (own == 2) ? m1_stb : 1'b0;
      tmo = gs && !s_ack_i && (stall == TMO - 1);
      if (mdl_on) begin
         chk("mdl_s_cyc",  s_cyc_o,  gc);
         chk("mdl_s_stb",  s_stb_o,  gs && !tmo);
         chk("mdl_m0_ack", m0_ack_o, (own == 1) && s_ack_i);
         chk("mdl_m1_ack", m1_ack_o, (own == 2) && s_ack_i);
         chk("mdl_m0_err", m0_err_o, (own == 1) && tmo);
         chk("mdl_m1_err", m1_err_o, (own == 2) && tmo);
         chk("mdl_s_adr",  s_adr_o,  (own == 2) ? m1_adr : m0_adr);
         chk("mdl_s_dat",  s_dat_o,  (own == 2) ? m1_dat : m0_dat);
         chk("mdl_s_sel",  s_sel_o,  (own == 2) ? m1_sel : m0_sel);
         chk("mdl_s_we",   s_we_o,   (own == 2) ? m1_we  : m0_we);
         chk("mdl_m0_dat", m0_dat_o, s_dat_i);
         chk("mdl_m1_dat", m1_dat_o, s_dat_i);
      end
      // advance the model to the state after the coming edge
      c0 = m0_cyc; c1 = m1_cyc;
      if (!rst_n) begin
         own = 0; fav = 0; stall = 0;
      end else if (own == 0) begin
         stall = 0;
         if (c0 && c1) own = fav + 1;
         else if (c0)  own = 1;
         else if (c1)  own = 2;
      end else if (!gc) begin
         fav   = (own == 1) ? 1 : 0;
         own   = (own == 1) ? (c1 ? 2 : 0) : (c0 ? 1 : 0);
         stall = 0;
      end else begin
         stall = (gs && !s_ack_i && !tmo) ? stall + 1 : 0;
      end
   end

   // ---------------- stimulus helpers
   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic setm(input int m, input logic on, input logic [31:0] adr,
                       input logic [31:0] dat, input logic we);
      if (m == 0) begin
         m0_cyc = on; m0_stb = on; m0_adr = adr; m0_dat = dat; m0_we = we; m0_sel = 4'hF;
      end else begin
         m1_cyc = on; m1_stb = on; m1_adr = adr; m1_dat = dat; m1_we = we; m1_sel = 4'hF;
      end
   endtask

   // Drop master m, then let the grant leave at the following edge
   task automatic release_m(input int m);
      tick();
      setm(m, 1'b0, 32'h0, 32'h0, 1'b0);
      tick();
   endtask

   // Call just after the grant edge; counts granted cycles until ack or err
   task automatic wait_done(input int m, input int budget, output int n,
                            output int ack, output int err, output int cyc1);
      n = 0; ack = 0; err = 0; cyc1 = 0;
      while (n < budget) begin
         @(negedge clk);
         n++;
         if (n == 1) cyc1 = s_cyc_o;
         ack = (m == 0) ? m0_ack_o : m1_ack_o;
         err = (m == 0) ? m0_err_o : m1_err_o;
         if (ack != 0 || err != 0) break;
      end
      if (ack == 0 && err == 0) chk("wait_bound", 32'(n), 32'hFFFF_FFFF);
   endtask

   int n, ack, err, cyc1;
   int order[$];

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      setm(0, 1'b0, 32'h0, 32'h0, 1'b0);
      setm(1, 1'b0, 32'h0, 32'h0, 1'b0);
      repeat (3) @(posedge clk);
      #1 mdl_on = 1'b1;
      @(negedge clk);
      chk("rst_s_cyc", s_cyc_o, 1'b0);
      chk("rst_s_stb", s_stb_o, 1'b0);
      chk("rst_ack_err", {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}, 4'b0);
      tick();
      rst_n = 1'b1;

      // single master write then read-back
      setm(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b1);
      @(negedge clk);
      chk("lat_before_grant", s_cyc_o, 1'b0);
      tick();
      wait_done(0, 20, n, ack, err, cyc1);
      chk("wr_cyc_next", cyc1, 1);
      chk("wr_ack", ack, 1);
      chk("wr_ack_cycle", n, 2);
      chk("wr_m1_ack", m1_ack_o, 1'b0);
      release_m(0);
      setm(0, 1'b1, 32'h10, 32'h0, 1'b0);
      tick();
      wait_done(0, 20, n, ack, err, cyc1);
      chk("rd_ack", ack, 1);
      chk("rd_data", m0_dat_o, 32'hDEADBEEF);
      chk("rd_m1_ack", m1_ack_o, 1'b0);
      release_m(0);

      // reset mid-transfer (favoured master is M1 at this point)
      slv_mode = 1;
      setm(0, 1'b1, 32'h20, 32'h0, 1'b0);
      repeat (3) tick();
      setm(1, 1'b1, 32'h24, 32'h0, 1'b0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      slv_mode = 0;
      @(negedge clk);
      chk("rstmid_s_cyc", s_cyc_o, 1'b0);
      chk("rstmid_ack_err", {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}, 4'b0);
      // simultaneous request right after reset: M0 favoured
      tick();
      wait_done(0, 20, n, ack, err, cyc1);
      chk("sim_m0_first_ack", ack, 1);
      chk("sim_m0_first_adr", s_adr_o, 32'h20);
      tick();
      setm(0, 1'b0, 32'h0, 32'h0, 1'b0);
      tick();
      @(negedge clk);
      chk("handover_cyc", s_cyc_o, 1'b1);
      chk("handover_adr", s_adr_o, 32'h24);
      wait_done(1, 20, n, ack, err, cyc1);
      chk("handover_m1_ack", ack, 1);
      release_m(1);

      // round-robin: both keep re-requesting single reads
      setm(0, 1'b1, 32'h40, 32'h0, 1'b0);
      setm(1, 1'b1, 32'h44, 32'h0, 1'b0);
      tick();
      begin
         bit off0 = 0, off1 = 0, dn0 = 0, dn1 = 0;
         for (int c = 0; c < 200 && order.size() < 8; c++) begin
            @(negedge clk);
            if (m0_ack_o) begin order.push_back(0); off0 = 1; end
            if (m1_ack_o) begin order.push_back(1); off1 = 1; end
            tick();
            if (dn0) begin setm(0, 1'b1, 32'h40, 32'h0, 1'b0); dn0 = 0; end
            if (dn1) begin setm(1, 1'b1, 32'h44, 32'h0, 1'b0); dn1 = 0; end
            if (off0) begin setm(0, 1'b0, 32'h0, 32'h0, 1'b0); off0 = 0; dn0 = 1; end
            if (off1) begin setm(1, 1'b0, 32'h0, 32'h0, 1'b0); off1 = 0; dn1 = 1; end
         end
      end
      setm(0, 1'b0, 32'h0, 32'h0, 1'b0);
      setm(1, 1'b0, 32'h0, 32'h0, 1'b0);
      tick(); tick();
      chk("rr_count", order.size(), 8);
      begin
         int c0 = 0;
         foreach (order[i]) begin
            chk("rr_order", order[i], i % 2);
            if (order[i] == 0) c0++;
         end
         chk("rr_m0_share", c0, 4);
      end

      // watchdog: slave never acks
      slv_mode = 1;
      setm(1, 1'b1, 32'h30, 32'h0, 1'b0);
      tick();
      wait_done(1, 40, n, ack, err, cyc1);
      chk("wd_err", err, 1);
      chk("wd_ack", ack, 0);
      chk("wd_cycle", n, TMO);
      chk("wd_stb_masked", s_stb_o, 1'b0);
      @(negedge clk);
      chk("wd_err_single", m1_err_o, 1'b0);
      chk("wd_stb_again", s_stb_o, 1'b1);
      release_m(1);

      // ack arriving exactly on the would-be timeout cycle
      slv_mode = 2;
      setm(1, 1'b1, 32'h34, 32'h0, 1'b0);
      tick();
      wait_done(1, 40, n, ack, err, cyc1);
      chk("race_ack", ack, 1);
      chk("race_err", m1_err_o, 1'b0);
      chk("race_cycle", n, TMO);
      chk("race_data", m1_dat_o, 32'h1000_000D);
      release_m(1);

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
